// File: rtl/rv32_mod_instruction_aligner_if.sv
// Fetch-side bundle for the instruction aligner: memory request/response,
// redirect from branch resolution, and the decoder-facing instruction stream.
interface rv32_mod_instruction_aligner_if;
    localparam int unsigned XLEN = 32;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instruction;
    logic [XLEN-1:0] out_pc;
    logic            out_is_compressed;

    modport master (
        output mem_req_valid, mem_req_addr,
        output out_valid, out_instruction, out_pc, out_is_compressed,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        input  out_valid, out_instruction, out_pc, out_is_compressed,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/rv32_mod_instruction_aligner.sv
// Instruction aligner: word-aligned fetch into a 3-halfword buffer, emitting one
// 16- or 32-bit instruction per handshake, with redirect and stale-response drop.
module rv32_mod_instruction_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                            clk,
    input  logic                            rst,
    rv32_mod_instruction_aligner_if.master  bus_io
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned HW   = 16;

    logic [2:0][HW-1:0] hwbuf_q, hwbuf_d;
    logic [1:0]         hw_cnt_q, hw_cnt_d;
    logic [1:0]         cnt_mid;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    fetch_addr_q, fetch_addr_d;
    logic               pending_q, pending_d;
    logic               drop_q, drop_d;
    logic               skip_low_q, skip_low_d;

    logic               head_compressed;
    logic               out_valid_c;
    logic               req_valid_c;
    logic               req_fire;
    logic               rsp_fire;
    logic               consume;
    logic               unused_redirect_bit0;

    assign unused_redirect_bit0 = bus_io.redirect_pc[0];

    assign head_compressed = (hwbuf_q[0][1:0] != 2'b11);
    assign out_valid_c     = ((hw_cnt_q != 2'd0) && head_compressed) || (hw_cnt_q >= 2'd2);
    assign req_valid_c     = !pending_q && (hw_cnt_q <= 2'd1) && !bus_io.redirect_valid;

    assign req_fire = req_valid_c && bus_io.mem_req_ready;
    assign rsp_fire = bus_io.mem_rsp_valid && pending_q;
    assign consume  = out_valid_c && bus_io.out_ready;

    assign bus_io.mem_req_valid     = req_valid_c;
    assign bus_io.mem_req_addr      = fetch_addr_q;
    assign bus_io.out_valid         = out_valid_c;
    assign bus_io.out_is_compressed = head_compressed;
    assign bus_io.out_pc            = pc_q;
    assign bus_io.out_instruction   = head_compressed ? {16'h0000, hwbuf_q[0]}
                                                      : {hwbuf_q[1], hwbuf_q[0]};

    // Redirect overrides everything; otherwise consume first, then append.
    always_comb begin
        hwbuf_d      = hwbuf_q;
        hw_cnt_d     = hw_cnt_q;
        cnt_mid      = hw_cnt_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        pending_d    = pending_q;
        drop_d       = drop_q;
        skip_low_d   = skip_low_q;

        if (bus_io.redirect_valid) begin
            hw_cnt_d     = 2'd0;
            pc_d         = {bus_io.redirect_pc[31:1], 1'b0};
            fetch_addr_d = {bus_io.redirect_pc[31:2], 2'b00};
            skip_low_d   = bus_io.redirect_pc[1];
            drop_d       = pending_q && !bus_io.mem_rsp_valid;
            pending_d    = pending_q && !bus_io.mem_rsp_valid;
        end else begin
            if (req_fire) begin
                pending_d    = 1'b1;
                fetch_addr_d = fetch_addr_q + XLEN'(4);
            end

            if (consume) begin
                if (head_compressed) begin
                    hwbuf_d = {hwbuf_q[2], hwbuf_q[2], hwbuf_q[1]};
                    cnt_mid = hw_cnt_q - 2'd1;
                    pc_d    = pc_q + XLEN'(2);
                end else begin
                    hwbuf_d = {hwbuf_q[2], hwbuf_q[2], hwbuf_q[2]};
                    cnt_mid = hw_cnt_q - 2'd2;
                    pc_d    = pc_q + XLEN'(4);
                end
            end
            hw_cnt_d = cnt_mid;

            if (rsp_fire) begin
                pending_d = 1'b0;
                if (drop_q) begin
                    drop_d = 1'b0;
                end else if (skip_low_q) begin
                    skip_low_d = 1'b0;
                    hw_cnt_d   = cnt_mid + 2'd1;
                    case (cnt_mid)
                        2'd0:    hwbuf_d[0] = bus_io.mem_rsp_data[31:16];
                        2'd1:    hwbuf_d[1] = bus_io.mem_rsp_data[31:16];
                        default: hwbuf_d[2] = bus_io.mem_rsp_data[31:16];
                    endcase
                end else begin
                    hw_cnt_d = cnt_mid + 2'd2;
                    case (cnt_mid)
                        2'd0: begin
                            hwbuf_d[0] = bus_io.mem_rsp_data[15:0];
                            hwbuf_d[1] = bus_io.mem_rsp_data[31:16];
                        end
                        2'd1: begin
                            hwbuf_d[1] = bus_io.mem_rsp_data[15:0];
                            hwbuf_d[2] = bus_io.mem_rsp_data[31:16];
                        end
                        default: hwbuf_d[2] = bus_io.mem_rsp_data[15:0];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwbuf_q      <= '0;
            hw_cnt_q     <= 2'd0;
            pc_q         <= RESET_PC;
            fetch_addr_q <= {RESET_PC[31:2], 2'b00};
            pending_q    <= 1'b0;
            drop_q       <= 1'b0;
            skip_low_q   <= RESET_PC[1];
        end else begin
            hwbuf_q      <= hwbuf_d;
            hw_cnt_q     <= hw_cnt_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            pending_q    <= pending_d;
            drop_q       <= drop_d;
            skip_low_q   <= skip_low_d;
        end
    end
endmodule

// File: tb/tb_rv32_mod_instruction_aligner.sv
// Directed self-checking bench for rv32_mod_instruction_aligner with a hand-driven
// one-cycle memory and decoder.
module tb_rv32_mod_instruction_aligner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    rv32_mod_instruction_aligner_if bus();

    rv32_mod_instruction_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.mem_req_ready  = 1'b0;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait (bounded) for a request, check its address, accept it, answer next cycle.
    task automatic serve(input logic [31:0] addr, input logic [31:0] data, input string name);
        int n = 0;
        while (!bus.mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.mem_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s req_timeout: mem_req_valid got %b expected 1", name, bus.mem_req_valid);
        end
        checks++;
        if (bus.mem_req_addr !== addr) begin
            failures++;
            $display("FAIL %s req_addr: got %h expected %h", name, bus.mem_req_addr, addr);
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = data;
        tick();
        bus.mem_rsp_valid = 1'b0;
    endtask

    task automatic consume_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc: got %h expected 00000000", bus.out_pc); end
        checks++;
        if (bus.out_instruction !== 32'h0) begin failures++; $display("FAIL reset_out_instr: got %h expected 00000000", bus.out_instruction); end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.mem_req_valid !== 1'b1) begin failures++; $display("FAIL reset_req_valid: got %b expected 1", bus.mem_req_valid); end
        checks++;
        if (bus.mem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr: got %h expected 00000000", bus.mem_req_addr); end
    endtask

    task automatic test_first_word();
        do_reset();
        serve(32'h0, 32'h00a0_0093, "first");
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL first_valid: got %b expected 1", bus.out_valid); end
        checks++;
        if (bus.out_instruction !== 32'h00a0_0093) begin failures++; $display("FAIL first_instr: got %h expected 00a00093", bus.out_instruction); end
        checks++;
        if (bus.out_pc !== 32'h0) begin failures++; $display("FAIL first_pc: got %h expected 00000000", bus.out_pc); end
        checks++;
        if (bus.out_is_compressed !== 1'b0) begin failures++; $display("FAIL first_is_c: got %b expected 0", bus.out_is_compressed); end
        consume_one();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL first_drained: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_compressed_pair();
        do_reset();
        serve(32'h0, 32'h4505_4501, "cpair");
        checks++;
        if (bus.out_instruction !== 32'h0000_4501 || bus.out_pc !== 32'h0 || bus.out_is_compressed !== 1'b1)
            begin failures++; $display("FAIL cpair_first: got %h@%h c=%b expected 00004501@00000000 c=1", bus.out_instruction, bus.out_pc, bus.out_is_compressed); end
        checks++;
        if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL cpair_stall_at_2: mem_req_valid got %b expected 0", bus.mem_req_valid); end
        consume_one();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instruction !== 32'h0000_4505 || bus.out_pc !== 32'h2)
            begin failures++; $display("FAIL cpair_second: got v=%b %h@%h expected v=1 00004505@00000002", bus.out_valid, bus.out_instruction, bus.out_pc); end
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h4)
            begin failures++; $display("FAIL cpair_next_req: got v=%b %h expected v=1 00000004", bus.mem_req_valid, bus.mem_req_addr); end
        consume_one();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL cpair_empty: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_straddle();
        do_reset();
        serve(32'h0, 32'h0093_0001, "straddle0");
        checks++;
        if (bus.out_instruction !== 32'h0000_0001 || bus.out_pc !== 32'h0 || bus.out_is_compressed !== 1'b1)
            begin failures++; $display("FAIL straddle_cnop: got %h@%h c=%b expected 00000001@00000000 c=1", bus.out_instruction, bus.out_pc, bus.out_is_compressed); end
        consume_one();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL straddle_partial: out_valid got %b expected 0", bus.out_valid); end
        serve(32'h4, 32'h4501_00a0, "straddle1");
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instruction !== 32'h00a0_0093 || bus.out_pc !== 32'h2 || bus.out_is_compressed !== 1'b0)
            begin failures++; $display("FAIL straddle_word: got v=%b %h@%h c=%b expected v=1 00a00093@00000002 c=0", bus.out_valid, bus.out_instruction, bus.out_pc, bus.out_is_compressed); end
        consume_one();
        checks++;
        if (bus.out_instruction !== 32'h0000_4501 || bus.out_pc !== 32'h6)
            begin failures++; $display("FAIL straddle_tail: got %h@%h expected 00004501@00000006", bus.out_instruction, bus.out_pc); end
    endtask

    task automatic test_redirect();
        do_reset();
        serve(32'h0, 32'h00a0_0093, "redir0");
        consume_one();
        serve(32'h4, 32'h00a0_0093, "redir1");
        consume_one();
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8)
            begin failures++; $display("FAIL redirect_req8: got v=%b %h expected v=1 00000008", bus.mem_req_valid, bus.mem_req_addr); end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0102;
        #1;
        checks++;
        if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL redirect_req_gate: got %b expected 0", bus.mem_req_valid); end
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.mem_req_valid !== 1'b0)
            begin failures++; $display("FAIL redirect_after: got out_valid=%b req=%b expected 0 0", bus.out_valid, bus.mem_req_valid); end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h1234_5677;
        tick();
        bus.mem_rsp_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL redirect_stale_drop: out_valid got %b expected 0", bus.out_valid); end
        serve(32'h100, 32'h4501_ffff, "redir2");
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instruction !== 32'h0000_4501 || bus.out_pc !== 32'h102 || bus.out_is_compressed !== 1'b1)
            begin failures++; $display("FAIL redirect_target: got v=%b %h@%h c=%b expected v=1 00004501@00000102 c=1", bus.out_valid, bus.out_instruction, bus.out_pc, bus.out_is_compressed); end
    endtask

    task automatic test_backpressure();
        do_reset();
        serve(32'h0, 32'h00a0_0093, "bp");
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_instruction !== 32'h00a0_0093 || bus.out_pc !== 32'h0 || bus.out_is_compressed !== 1'b0)
                begin failures++; $display("FAIL bp_hold[%0d]: got v=%b %h@%h c=%b expected v=1 00a00093@00000000 c=0", i, bus.out_valid, bus.out_instruction, bus.out_pc, bus.out_is_compressed); end
            checks++;
            if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req[%0d]: got %b expected 0", i, bus.mem_req_valid); end
            tick();
        end
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        serve(32'h0, 32'h0093_0001, "rmid0");
        consume_one();
        serve(32'h4, 32'h4501_00a0, "rmid1");
        consume_one();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h6)
            begin failures++; $display("FAIL rmid_pre: got v=%b pc=%h expected v=1 pc=00000006", bus.out_valid, bus.out_pc); end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_instruction !== 32'h0)
            begin failures++; $display("FAIL rmid_async: got v=%b %h@%h expected v=0 00000000@00000000", bus.out_valid, bus.out_instruction, bus.out_pc); end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0)
            begin failures++; $display("FAIL rmid_restart: got v=%b %h expected v=1 00000000", bus.mem_req_valid, bus.mem_req_addr); end
        serve(32'h0, 32'h4505_4501, "rmid2");
        checks++;
        if (bus.out_instruction !== 32'h0000_4501 || bus.out_pc !== 32'h0)
            begin failures++; $display("FAIL rmid_first: got %h@%h expected 00004501@00000000", bus.out_instruction, bus.out_pc); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_compressed_pair();
        test_straddle();
        test_redirect();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
